// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit.
// Contents:
//   lsu_size_t      - access size encoding (byte, half, word, double)
//   lsu_err_t       - descriptor rejection codes
//   lsu_size_bytes  - access size in bytes for a given lsu_size_t
package lsu_pkg;

    typedef enum logic [1:0] {
        LSU_SIZE_B = 2'b00,
        LSU_SIZE_H = 2'b01,
        LSU_SIZE_W = 2'b10,
        LSU_SIZE_D = 2'b11
    } lsu_size_t;

    typedef enum logic [1:0] {
        LSU_ERR_NONE  = 2'b00,
        LSU_ERR_SIZE  = 2'b01,
        LSU_ERR_ALIGN = 2'b10
    } lsu_err_t;

    function automatic logic [3:0] lsu_size_bytes(input lsu_size_t size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/lsu_load_return_if.sv
// Handshake bundle between upstream issue, memory response, register-file
// write-back and the load-return stage.
// Groups:
//   req_*      load descriptor (valid/ready)
//   mem_rsp_*  in-order memory response (valid/ready)
//   flush      kill all outstanding loads
//   wb_*       register-file write-back (valid/ready)
//   err_*      one-cycle descriptor rejection report
// Modports: master = environment side, slave = lsu_load_return.
//
// Handshake rule for every valid/ready pair: a transfer happens on a rising
// clock edge where both valid and ready are high; the producer holds valid and
// its payload stable until that transfer, and ready may depend on state only
// (never on the valid of the same channel).
interface lsu_load_return_if
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int RA_W = 5,
    localparam int OFF_W = $clog2(XLEN / 8)
) ();

    logic             req_valid;
    logic             req_ready;
    logic [RA_W-1:0]  req_rd;
    lsu_size_t        req_size;
    logic             req_zero_ext;
    logic [OFF_W-1:0] req_offset;

    logic             mem_rsp_valid;
    logic             mem_rsp_ready;
    logic [XLEN-1:0]  mem_rsp_data;

    logic             flush;

    logic             wb_valid;
    logic             wb_ready;
    logic [RA_W-1:0]  wb_rd;
    logic [XLEN-1:0]  wb_data;

    logic             err_valid;
    lsu_err_t         err_code;

    modport master (
        output req_valid, req_rd, req_size, req_zero_ext, req_offset,
        output mem_rsp_valid, mem_rsp_data, flush, wb_ready,
        input  req_ready, mem_rsp_ready, wb_valid, wb_rd, wb_data,
        input  err_valid, err_code
    );

    modport slave (
        input  req_valid, req_rd, req_size, req_zero_ext, req_offset,
        input  mem_rsp_valid, mem_rsp_data, flush, wb_ready,
        output req_ready, mem_rsp_ready, wb_valid, wb_rd, wb_data,
        output err_valid, err_code
    );

endinterface

// File: rtl/lsu_load_extract.sv
// Combinational load-data extraction: shifts the raw memory word right by
// the byte offset, then sign- or zero-extends the accessed field to XLEN.
// Ports:
//   data      in  XLEN   raw memory word
//   offset    in  OFF_W  byte offset of the access inside the word
//   size      in  2      access size (lsu_size_t)
//   zero_ext  in  1      1 = zero-fill, 0 = replicate the field's top bit
//   result    out XLEN   extended value
module lsu_load_extract
    import lsu_pkg::*;
#(
    parameter int XLEN = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  data,
    input  logic [OFF_W-1:0] offset,
    input  lsu_size_t        size,
    input  logic             zero_ext,
    output logic [XLEN-1:0]  result
);

    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] keep_mask;
    logic            sign;
    logic            fill;

    assign shifted = data >> {offset, 3'b000};

    // keep_mask selects the bits belonging to the accessed field; everything
    // above it is replaced by the fill bit.
    always_comb begin
        keep_mask = '1;
        sign      = shifted[XLEN-1];
        unique case (size)
            LSU_SIZE_B: begin
                keep_mask = XLEN'(8'hFF);
                sign      = shifted[7];
            end
            LSU_SIZE_H: begin
                keep_mask = XLEN'(16'hFFFF);
                sign      = shifted[15];
            end
            LSU_SIZE_W: begin
                keep_mask = XLEN'(32'hFFFF_FFFF);
                sign      = shifted[31];
            end
            LSU_SIZE_D: begin
                keep_mask = '1;
                sign      = shifted[XLEN-1];
            end
        endcase
    end

    assign fill   = sign & ~zero_ext;
    assign result = (shifted & keep_mask) | (~keep_mask & {XLEN{fill}});

endmodule

// File: rtl/lsu_load_return.sv
// Load-return stage. Queues up to DEPTH load descriptors in issue order,
// pairs each in-order memory response with the head descriptor, aligns and
// extends the data, and holds the result in a registered write-back port.
// Ports:
//   clk   in  clock, rising edge
//   rst   in  synchronous active-high reset
//   bus   slave modport of lsu_load_return_if (req, mem_rsp, flush, wb, err)
// req_ready and mem_rsp_ready are combinational from state and wb_ready;
// every other output is registered.
module lsu_load_return
    import lsu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int RA_W  = 5
) (
    input logic               clk,
    input logic               rst,
    lsu_load_return_if.slave  bus
);

    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int AW    = $clog2(DEPTH);
    localparam int PW    = AW + 1;

    // Descriptor storage
    logic [RA_W-1:0]  q_rd   [DEPTH];
    lsu_size_t        q_size [DEPTH];
    logic             q_zext [DEPTH];
    logic [OFF_W-1:0] q_off  [DEPTH];
    logic [DEPTH-1:0] q_kill;

    // Pointers carry one extra MSB so full and empty are distinguishable.
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] count;
    logic [AW-1:0] head_idx;
    logic [AW-1:0] tail_idx;
    logic          full;
    logic          empty;

    // Output registers
    logic             wb_valid_q;
    logic [RA_W-1:0]  wb_rd_q;
    logic [XLEN-1:0]  wb_data_q;
    logic             err_valid_q;
    lsu_err_t         err_code_q;

    lsu_err_t         req_err;
    logic             req_fire;
    logic             enq;
    logic             rej;
    logic             rsp_fire;
    logic             rsp_live;
    logic [DEPTH-1:0] live_mask;
    logic [XLEN-1:0]  ext_data;

    assign count    = tail - head;
    assign head_idx = head[AW-1:0];
    assign tail_idx = tail[AW-1:0];
    assign full     = (count == PW'(DEPTH));
    assign empty    = (head == tail);

    assign bus.req_ready     = !full;
    assign bus.mem_rsp_ready = !empty && (!wb_valid_q || bus.wb_ready);

    // Descriptor legality: size/extension combination first, then alignment.
    always_comb begin
        logic size_ok;
        size_ok = 1'b0;
        unique case (bus.req_size)
            LSU_SIZE_B: size_ok = 1'b1;
            LSU_SIZE_H: size_ok = 1'b1;
            LSU_SIZE_W: size_ok = !bus.req_zero_ext || (XLEN == 64);
            LSU_SIZE_D: size_ok = !bus.req_zero_ext && (XLEN == 64);
        endcase
        req_err = LSU_ERR_NONE;
        if (!size_ok) begin
            req_err = LSU_ERR_SIZE;
        end else if ((4'(bus.req_offset) & (lsu_size_bytes(bus.req_size) - 4'd1)) != 4'd0) begin
            req_err = LSU_ERR_ALIGN;
        end
    end

    assign req_fire = bus.req_valid && !full;
    assign enq      = req_fire && (req_err == LSU_ERR_NONE);
    assign rej      = req_fire && (req_err != LSU_ERR_NONE);

    // A response consumed in the flush cycle counts as killed.
    assign rsp_fire = bus.mem_rsp_valid && bus.mem_rsp_ready;
    assign rsp_live = rsp_fire && !q_kill[head_idx] && !bus.flush;

    // Entries between head (inclusive) and tail (exclusive) are outstanding.
    always_comb begin
        live_mask = '0;
        for (int i = 0; i < DEPTH; i++) begin
            live_mask[i] = ({1'b0, AW'(i) - head_idx} < count);
        end
    end

    lsu_load_extract #(.XLEN(XLEN)) u_extract (
        .data     (bus.mem_rsp_data),
        .offset   (q_off[head_idx]),
        .size     (q_size[head_idx]),
        .zero_ext (q_zext[head_idx]),
        .result   (ext_data)
    );

    // Control state, kill bits and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            q_kill      <= '0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            err_valid_q <= 1'b0;
            err_code_q  <= LSU_ERR_NONE;
        end else begin
            err_valid_q <= rej;
            err_code_q  <= rej ? req_err : LSU_ERR_NONE;

            if (rsp_fire) begin
                head <= head + PW'(1);
            end

            // The flush only marks entries already outstanding; the slot written
            // by a same-cycle enqueue is never among them (enqueue needs !full),
            // and the enqueue write below clears that slot's kill bit anyway.
            if (bus.flush) begin
                q_kill <= q_kill | live_mask;
            end
            if (enq) begin
                q_kill[tail_idx] <= 1'b0;
                tail             <= tail + PW'(1);
            end

            if (bus.flush) begin
                wb_valid_q <= 1'b0;
            end else if (rsp_live) begin
                wb_valid_q <= 1'b1;
                wb_rd_q    <= q_rd[head_idx];
                wb_data_q  <= ext_data;
            end else if (bus.wb_ready) begin
                wb_valid_q <= 1'b0;
            end
        end
    end

    // Descriptor payload needs no reset: an entry is only read once written.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_rd[tail_idx]   <= bus.req_rd;
            q_size[tail_idx] <= bus.req_size;
            q_zext[tail_idx] <= bus.req_zero_ext;
            q_off[tail_idx]  <= bus.req_offset;
        end
    end

    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.err_valid = err_valid_q;
    assign bus.err_code  = err_code_q;

    // Memory must never present a response with no load outstanding.
    a_rsp_when_empty: assert property (@(posedge clk) disable iff (rst)
        !(bus.mem_rsp_valid && empty));

endmodule

// File: tb/tb_lsu_load_return.sv
// Directed testbench for lsu_load_return: one 32-bit and one 64-bit instance.
// Inputs change 1 time unit after a rising edge; outputs are sampled there.
module tb_lsu_load_return;
    import lsu_pkg::*;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    lsu_load_return_if #(.XLEN(32), .RA_W(5)) bus32 ();
    lsu_load_return_if #(.XLEN(64), .RA_W(5)) bus64 ();

    lsu_load_return #(.XLEN(32), .DEPTH(4), .RA_W(5)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    lsu_load_return #(.XLEN(64), .DEPTH(4), .RA_W(5)) dut64 (
        .clk (clk),
        .rst (rst),
        .bus (bus64)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks, 32-bit instance
    task automatic enq32(input logic [4:0] rd, input lsu_size_t size, input logic zext,
                         input logic [2:0] off);
        bus32.req_rd       = rd;
        bus32.req_size     = size;
        bus32.req_zero_ext = zext;
        bus32.req_offset   = off[1:0];
        bus32.req_valid    = 1'b1;
        chk("enq32_req_ready", 64'(bus32.req_ready), 64'd1);
        tick();
        bus32.req_valid    = 1'b0;
    endtask

    task automatic rsp32(input logic [63:0] d);
        int n;
        n = 0;
        bus32.mem_rsp_valid = 1'b1;
        bus32.mem_rsp_data  = d[31:0];
        #1;
        while (!bus32.mem_rsp_ready && n < 20) begin
            tick();
            n++;
        end
        chk("rsp32_accept", 64'(bus32.mem_rsp_ready), 64'd1);
        tick();
        bus32.mem_rsp_valid = 1'b0;
        bus32.mem_rsp_data  = '0;
    endtask

    // Full load with wb_ready held high: result visible one cycle after the response.
    task automatic load32(input string tag, input logic [4:0] rd, input lsu_size_t size,
                          input logic zext, input logic [2:0] off,
                          input logic [63:0] d, input logic [63:0] exp);
        enq32(rd, size, zext, off);
        rsp32(d);
        chk({tag, "_wb_valid"}, 64'(bus32.wb_valid), 64'd1);
        chk({tag, "_wb_rd"}, 64'(bus32.wb_rd), 64'(rd));
        chk({tag, "_wb_data"}, 64'(bus32.wb_data), exp);
        tick();
        chk({tag, "_wb_drop"}, 64'(bus32.wb_valid), 64'd0);
    endtask

    task automatic illegal32(input string tag, input lsu_size_t size, input logic zext,
                             input logic [2:0] off, input lsu_err_t code);
        enq32(5'd20, size, zext, off);
        chk({tag, "_err_valid"}, 64'(bus32.err_valid), 64'd1);
        chk({tag, "_err_code"}, 64'(bus32.err_code), 64'(code));
        chk({tag, "_not_queued"}, 64'(bus32.mem_rsp_ready), 64'd0);
        tick();
        chk({tag, "_err_pulse"}, 64'(bus32.err_valid), 64'd0);
    endtask

    // Driver tasks, 64-bit instance (wb_ready held high)
    task automatic enq64(input logic [4:0] rd, input lsu_size_t size, input logic zext,
                         input logic [2:0] off);
        bus64.req_rd       = rd;
        bus64.req_size     = size;
        bus64.req_zero_ext = zext;
        bus64.req_offset   = off;
        bus64.req_valid    = 1'b1;
        chk("enq64_req_ready", 64'(bus64.req_ready), 64'd1);
        tick();
        bus64.req_valid    = 1'b0;
    endtask

    task automatic load64(input string tag, input logic [4:0] rd, input lsu_size_t size,
                          input logic zext, input logic [2:0] off,
                          input logic [63:0] d, input logic [63:0] exp);
        int n;
        enq64(rd, size, zext, off);
        n = 0;
        bus64.mem_rsp_valid = 1'b1;
        bus64.mem_rsp_data  = d;
        #1;
        while (!bus64.mem_rsp_ready && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_accept"}, 64'(bus64.mem_rsp_ready), 64'd1);
        tick();
        bus64.mem_rsp_valid = 1'b0;
        chk({tag, "_wb_valid"}, 64'(bus64.wb_valid), 64'd1);
        chk({tag, "_wb_rd"}, 64'(bus64.wb_rd), 64'(rd));
        chk({tag, "_wb_data"}, bus64.wb_data, exp);
        tick();
        chk({tag, "_wb_drop"}, 64'(bus64.wb_valid), 64'd0);
    endtask

    task automatic illegal64(input string tag, input lsu_size_t size, input logic zext,
                             input logic [2:0] off, input lsu_err_t code);
        enq64(5'd21, size, zext, off);
        chk({tag, "_err_valid"}, 64'(bus64.err_valid), 64'd1);
        chk({tag, "_err_code"}, 64'(bus64.err_code), 64'(code));
        chk({tag, "_not_queued"}, 64'(bus64.mem_rsp_ready), 64'd0);
        tick();
        chk({tag, "_err_pulse"}, 64'(bus64.err_valid), 64'd0);
    endtask

    initial begin
        rst = 1'b1;
        bus32.req_valid = 1'b0; bus32.req_rd = '0; bus32.req_size = LSU_SIZE_B;
        bus32.req_zero_ext = 1'b0; bus32.req_offset = '0;
        bus32.mem_rsp_valid = 1'b0; bus32.mem_rsp_data = '0;
        bus32.flush = 1'b0; bus32.wb_ready = 1'b0;
        bus64.req_valid = 1'b0; bus64.req_rd = '0; bus64.req_size = LSU_SIZE_B;
        bus64.req_zero_ext = 1'b0; bus64.req_offset = '0;
        bus64.mem_rsp_valid = 1'b0; bus64.mem_rsp_data = '0;
        bus64.flush = 1'b0; bus64.wb_ready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_req_ready", 64'(bus32.req_ready), 64'd1);
        chk("rst_rsp_ready", 64'(bus32.mem_rsp_ready), 64'd0);
        chk("rst_wb_valid", 64'(bus32.wb_valid), 64'd0);
        chk("rst_wb_data", 64'(bus32.wb_data), 64'd0);
        chk("rst_err_valid", 64'(bus32.err_valid), 64'd0);
        chk("rst64_req_ready", 64'(bus64.req_ready), 64'd1);
        chk("rst64_wb_valid", 64'(bus64.wb_valid), 64'd0);

        // Signed byte at offset 2: 0x12803456 >> 16 -> byte 0x80 -> 0xFFFFFF80
        enq32(5'd3, LSU_SIZE_B, 1'b0, 3'd2);
        chk("lb_rsp_ready_next", 64'(bus32.mem_rsp_ready), 64'd1);
        chk("lb_wb_idle", 64'(bus32.wb_valid), 64'd0);
        rsp32(64'h1280_3456);
        chk("lb_wb_valid", 64'(bus32.wb_valid), 64'd1);
        chk("lb_wb_rd", 64'(bus32.wb_rd), 64'd3);
        chk("lb_wb_data", 64'(bus32.wb_data), 64'hFFFF_FF80);
        bus32.wb_ready = 1'b1;
        tick();
        chk("lb_wb_drop", 64'(bus32.wb_valid), 64'd0);

        // More extraction patterns
        load32("lhu", 5'd4, LSU_SIZE_H, 1'b1, 3'd2, 64'hABCD_1234, 64'h0000_ABCD);
        load32("lh", 5'd5, LSU_SIZE_H, 1'b0, 3'd0, 64'h0000_8001, 64'hFFFF_8001);
        load32("lw", 5'd6, LSU_SIZE_W, 1'b0, 3'd0, 64'hDEAD_BEEF, 64'hDEAD_BEEF);
        load32("lbu", 5'd7, LSU_SIZE_B, 1'b1, 3'd3, 64'hF000_0000, 64'h0000_00F0);

        // Illegal descriptors
        illegal32("lh_misaligned", LSU_SIZE_H, 1'b0, 3'd1, LSU_ERR_ALIGN);
        illegal32("lw_misaligned", LSU_SIZE_W, 1'b0, 3'd2, LSU_ERR_ALIGN);
        illegal32("ld32", LSU_SIZE_D, 1'b0, 3'd0, LSU_ERR_SIZE);
        illegal32("ldu32", LSU_SIZE_D, 1'b1, 3'd0, LSU_ERR_SIZE);
        illegal32("lwu32", LSU_SIZE_W, 1'b1, 3'd0, LSU_ERR_SIZE);

        // Full queue and write-back backpressure
        bus32.wb_ready = 1'b0;
        enq32(5'd1, LSU_SIZE_B, 1'b0, 3'd1);
        enq32(5'd2, LSU_SIZE_H, 1'b0, 3'd2);
        enq32(5'd3, LSU_SIZE_B, 1'b1, 3'd0);
        enq32(5'd4, LSU_SIZE_W, 1'b0, 3'd0);
        chk("full_req_ready", 64'(bus32.req_ready), 64'd0);
        bus32.mem_rsp_valid = 1'b1;
        bus32.mem_rsp_data  = 32'h0000_7F00;
        #1;
        chk("bp_rsp1_ready", 64'(bus32.mem_rsp_ready), 64'd1);
        tick();
        chk("bp_wb1_valid", 64'(bus32.wb_valid), 64'd1);
        chk("bp_wb1_rd", 64'(bus32.wb_rd), 64'd1);
        chk("bp_wb1_data", 64'(bus32.wb_data), 64'h0000_007F);
        chk("bp_stall_ready", 64'(bus32.mem_rsp_ready), 64'd0);
        chk("bp_not_full", 64'(bus32.req_ready), 64'd1);
        bus32.mem_rsp_data = 32'hFFFE_0000;
        tick();
        chk("bp_hold_valid", 64'(bus32.wb_valid), 64'd1);
        chk("bp_hold_rd", 64'(bus32.wb_rd), 64'd1);
        chk("bp_hold_data", 64'(bus32.wb_data), 64'h0000_007F);
        chk("bp_hold_stall", 64'(bus32.mem_rsp_ready), 64'd0);
        bus32.wb_ready = 1'b1;
        #1;
        chk("bp_release_ready", 64'(bus32.mem_rsp_ready), 64'd1);
        tick();
        chk("bp_wb2_rd", 64'(bus32.wb_rd), 64'd2);
        chk("bp_wb2_data", 64'(bus32.wb_data), 64'hFFFF_FFFE);
        chk("bp_wb2_valid", 64'(bus32.wb_valid), 64'd1);
        bus32.mem_rsp_data = 32'h0000_00FF;
        tick();
        chk("bp_wb3_rd", 64'(bus32.wb_rd), 64'd3);
        chk("bp_wb3_data", 64'(bus32.wb_data), 64'h0000_00FF);
        chk("bp_wb3_valid", 64'(bus32.wb_valid), 64'd1);
        bus32.mem_rsp_data = 32'h1357_9BDF;
        tick();
        bus32.mem_rsp_valid = 1'b0;
        chk("bp_wb4_rd", 64'(bus32.wb_rd), 64'd4);
        chk("bp_wb4_data", 64'(bus32.wb_data), 64'h1357_9BDF);
        chk("bp_wb4_valid", 64'(bus32.wb_valid), 64'd1);
        tick();
        chk("bp_drained_wb", 64'(bus32.wb_valid), 64'd0);
        chk("bp_drained_rsp", 64'(bus32.mem_rsp_ready), 64'd0);

        // Flush: pending write-back dropped, three loads killed, same-cycle load lives
        bus32.wb_ready = 1'b0;
        enq32(5'd9, LSU_SIZE_W, 1'b0, 3'd0);
        rsp32(64'hCAFE_F00D);
        chk("fl_pre_wb_valid", 64'(bus32.wb_valid), 64'd1);
        enq32(5'd5, LSU_SIZE_B, 1'b0, 3'd0);
        enq32(5'd6, LSU_SIZE_B, 1'b0, 3'd1);
        enq32(5'd7, LSU_SIZE_B, 1'b0, 3'd2);
        bus32.flush = 1'b1;
        enq32(5'd8, LSU_SIZE_H, 1'b0, 3'd2);
        bus32.flush = 1'b0;
        chk("fl_wb_cleared", 64'(bus32.wb_valid), 64'd0);
        chk("fl_full", 64'(bus32.req_ready), 64'd0);
        bus32.wb_ready = 1'b1;
        rsp32(64'h1111_1111);
        chk("fl_kill1", 64'(bus32.wb_valid), 64'd0);
        rsp32(64'h2222_2222);
        chk("fl_kill2", 64'(bus32.wb_valid), 64'd0);
        rsp32(64'h3333_3333);
        chk("fl_kill3", 64'(bus32.wb_valid), 64'd0);
        rsp32(64'h8001_0000);
        chk("fl_live_valid", 64'(bus32.wb_valid), 64'd1);
        chk("fl_live_rd", 64'(bus32.wb_rd), 64'd8);
        chk("fl_live_data", 64'(bus32.wb_data), 64'hFFFF_8001);
        tick();
        chk("fl_live_drop", 64'(bus32.wb_valid), 64'd0);

        // Mid-operation reset
        bus32.wb_ready = 1'b0;
        enq32(5'd11, LSU_SIZE_B, 1'b0, 3'd0);
        enq32(5'd12, LSU_SIZE_B, 1'b0, 3'd1);
        enq32(5'd13, LSU_SIZE_B, 1'b0, 3'd2);
        rsp32(64'h0000_00AA);
        chk("mr_wb_valid", 64'(bus32.wb_valid), 64'd1);
        chk("mr_wb_data", 64'(bus32.wb_data), 64'hFFFF_FFAA);
        enq32(5'd14, LSU_SIZE_D, 1'b0, 3'd0);
        chk("mr_err_valid", 64'(bus32.err_valid), 64'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mr_wb_valid0", 64'(bus32.wb_valid), 64'd0);
        chk("mr_wb_rd0", 64'(bus32.wb_rd), 64'd0);
        chk("mr_wb_data0", 64'(bus32.wb_data), 64'd0);
        chk("mr_err_valid0", 64'(bus32.err_valid), 64'd0);
        chk("mr_err_code0", 64'(bus32.err_code), 64'd0);
        chk("mr_req_ready", 64'(bus32.req_ready), 64'd1);
        chk("mr_rsp_ready", 64'(bus32.mem_rsp_ready), 64'd0);
        bus32.wb_ready = 1'b1;
        load32("post_rst", 5'd15, LSU_SIZE_B, 1'b1, 3'd3, 64'hAB00_0000, 64'h0000_00AB);

        // 64-bit datapath
        load64("lwu64", 5'd10, LSU_SIZE_W, 1'b1, 3'd4,
               64'h8000_0001_1234_5678, 64'h0000_0000_8000_0001);
        load64("lw64", 5'd11, LSU_SIZE_W, 1'b0, 3'd4,
               64'h8000_0001_1234_5678, 64'hFFFF_FFFF_8000_0001);
        load64("ld64", 5'd12, LSU_SIZE_D, 1'b0, 3'd0,
               64'h8123_4567_89AB_CDEF, 64'h8123_4567_89AB_CDEF);
        load64("lbu64", 5'd13, LSU_SIZE_B, 1'b1, 3'd7,
               64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE);
        load64("lh64", 5'd14, LSU_SIZE_H, 1'b0, 3'd6,
               64'h9ABC_0000_0000_0000, 64'hFFFF_FFFF_FFFF_9ABC);
        illegal64("ldu64", LSU_SIZE_D, 1'b1, 3'd0, LSU_ERR_SIZE);
        illegal64("lw64_misaligned", LSU_SIZE_W, 1'b0, 3'd2, LSU_ERR_ALIGN);
        illegal64("ld64_misaligned", LSU_SIZE_D, 1'b0, 3'd4, LSU_ERR_ALIGN);

        // Final report
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lsu_load_return.md
# lsu_load_return

Parametrised load-return stage of the LSU. Tracks up to `DEPTH` outstanding loads in issue order, and pairs each in-order memory response with its queued descriptor. It aligns the returned data by byte offset, sign- or zero-extends it by access size, and presents a registered write-back to the register-file port over a valid/ready handshake. It adds an XLEN-generic datapath, byte-offset alignment, outstanding-load buffering, flush/kill, backpressure and error reporting.

## Interface
- `XLEN`, 32: datapath width; legal values are 32 and 64.
- `DEPTH`, 4: maximum outstanding loads; must be a power of two, ≥2.
- `RA_W`, 5: register address width.
- `OFF_W`, derived `$clog2(XLEN/8)`: width of the byte offset.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  a load descriptor is offered (loads only; stores/NOPs never offered).
- `req_ready`  out  1  the descriptor queue can accept.
- `req_rd`  in  RA_W  destination register.
- `req_size`  in  2  `lsu_size_t`: 00 byte, 01 half, 10 word, 11 double.
- `req_zero_ext`  in  1  unsigned load.
- `req_offset`  in  OFF_W  byte offset of the access within the XLEN word.
- `mem_rsp_valid`  in  1  memory response present (in order).
- `mem_rsp_ready`  out  1  response consumed this cycle.
- `mem_rsp_data`  in  XLEN  raw aligned memory word.
- `flush`  in  1  kill all outstanding loads.
- `wb_valid`  out  1  write-back pending.
- `wb_ready`  in  1  register-file port accepts.
- `wb_rd`  out  RA_W  write-back register.
- `wb_data`  out  XLEN  extended load result.
- `err_valid`  out  1  one-cycle pulse when a descriptor is rejected.
- `err_code`  out  2  `lsu_err_t`: 01 invalid size/ext combination, 10 misaligned.

## Operation
- **Legal descriptors:**
  - XLEN=32 accepts B/H/W signed and B/H unsigned.
  - XLEN=64 additionally accepts W unsigned (LWU) and D signed.
  - D unsigned and any other combination → invalid.
  - Misaligned means `req_offset` is not a multiple of the access size in bytes.
- **Enqueue:** on `req_valid && req_ready`.
  - A legal descriptor is written to the tail entry with kill=0.
  - An illegal descriptor is not enqueued, and `err_valid`/`err_code` pulse the next cycle.
  - Upstream must not issue memory traffic for a rejected load.
  - `req_ready = !full`. There is no enqueue-on-full even when a dequeue happens the same cycle.
- **Response:** `mem_rsp_ready = !empty && (!wb_valid || wb_ready)`.
  - On handshake, the head entry is dequeued.
  - The datapath computes `mem_rsp_data >> (8*offset)`, then applies the extension.
  - Signed loads replicate the top bit of the accessed field. Unsigned loads zero-fill.
  - If the head entry's kill=0, the result loads the output register and `wb_valid` is set.
  - If kill=1, the response is consumed silently and `wb_valid` is unchanged.
- **Write-back:** `wb_valid`/`wb_rd`/`wb_data` hold stable until `wb_ready`.
  - `wb_valid` clears on handshake unless a new live response loads in the same cycle.
- **Flush:** sets kill on every currently valid entry and clears `wb_valid`.
  - Pointers are unchanged; memory still returns those responses, which are drained.
  - A request enqueued in the flush cycle is NOT killed.
  - A response dequeued in the flush cycle is treated as killed.
- **`rst`:** clears head, tail, count, all kill bits, `wb_valid`, `wb_rd`, `wb_data` and `err_valid`/`err_code` to 0.
  - Reset mid-operation abandons outstanding loads; the memory side is reset by the same `rst`.
- **`mem_rsp_valid` while empty:** not accepted (`mem_rsp_ready=0`); the protocol forbids it.
  - Simulation asserts flag it.

## Timing
- All outputs are registered, except `req_ready` and `mem_rsp_ready`, which are combinational from state and `wb_ready`.
- Enqueue in cycle N → response acceptable from N+1 (no same-cycle bypass).
- Response accepted in cycle N → `wb_valid` high in N+1.
- Sustained throughput is 1 load/cycle with `wb_ready` held high.
- Count wraps via pointer MSB; head and tail wrap modulo DEPTH.
- Simultaneous enqueue and dequeue leaves the count unchanged.

## Structure
- `lsu_pkg`:
  - `lsu_size_t` enum (`LSU_SIZE_B/H/W/D`)
  - `lsu_err_t` enum (`LSU_ERR_NONE/SIZE/ALIGN`)
  - function `lsu_size_bytes()`
- Sub-module `lsu_load_extract`: combinational shift/extend, parametrised by XLEN, shared with future store-data alignment.
- Queue storage, pointers, kill bits and the output register live in the top level.

## Test plan
- **Signed byte:** XLEN=32, LB, offset 2, data 0x12_80_34_56 → `wb_data` 0xFFFFFF80, `wb_valid` one cycle after the response.
- **Unsigned 64-bit:** XLEN=64, LWU, offset 4, data 0x8000_0001_xxxx_xxxx → `wb_data` 0x0000_0000_8000_0001. Signed LW on the same data → 0xFFFF_FFFF_8000_0001.
- **Illegal descriptors:**
  - LH at offset 1 → `err_code`=10 pulse, count unchanged.
  - LD or D unsigned on XLEN=32 → `err_code`=01.
- **Full/backpressure:**
  - Enqueue DEPTH loads → `req_ready`=0.
  - Hold `wb_ready`=0 → `mem_rsp_ready`=0 after the first response. Results stay stable.
  - Release `wb_ready` → 4 write-backs on consecutive cycles, in order.
- **Flush:** three loads outstanding, `flush`, then one new load → the first three responses produce no write-back, the fourth does.
- **Mid-operation reset:** `rst` asserted with two loads outstanding and `wb_valid`=1 → next cycle all outputs are 0 and `req_ready`=1.
